// File: rtl/nt_pkg.sv
// Shared definitions for the neurotransmitter bank: channel indices, default
// sizing and the 2-bit level encoding consumed by the emotion logic.
package nt_pkg;

   localparam int NT_CORTISOL       = 0;
   localparam int NT_DOPAMINE       = 1;
   localparam int NT_GABA           = 2;
   localparam int NT_NOREPINEPHRINE = 3;
   localparam int NT_SEROTONIN      = 4;

   localparam int NT_NUM_CH       = 5;
   localparam int NT_ACC_W        = 7;
   localparam int NT_LVL_W        = 2;
   localparam int NT_STEP         = 4;
   localparam int NT_BASELINE     = 64;
   localparam int NT_DECAY_PERIOD = 16;

   typedef enum logic [1:0] {
      LOW       = 2'b00,
      NORMAL    = 2'b01,
      HIGH      = 2'b10,
      VERY_HIGH = 2'b11
   } nt_level_e;

endpackage

// File: rtl/nt_channel.sv
// One transmitter channel: saturating accumulator, decay toward baseline and
// quantised level register. NT_BANK_DEBUG_EN exposes the raw accumulator.
module nt_channel
   import nt_pkg::*;
#(
   parameter int ACC_W    = NT_ACC_W,
   parameter int LVL_W    = NT_LVL_W,
   parameter int STEP     = NT_STEP,
   parameter int BASELINE = NT_BASELINE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             stim_up,
   input  logic             stim_dn,
   input  logic             hold,
   input  logic             decay_step,
   output logic [LVL_W-1:0] level
`ifdef NT_BANK_DEBUG_EN
   ,output logic [ACC_W-1:0] acc_raw
`endif
);

   localparam logic [ACC_W-1:0] BASE_V  = ACC_W'(BASELINE);
   localparam logic [ACC_W:0]   STEP_V  = (ACC_W+1)'(STEP);
   localparam logic [LVL_W-1:0] LVL_RST = BASE_V[ACC_W-1 -: LVL_W];

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;

   // The extra top bit catches both carry-out and borrow so neither can wrap.
   function automatic logic [ACC_W-1:0] sat_up(input logic [ACC_W-1:0] a);
      logic [ACC_W:0] s;
      s = {1'b0, a} + STEP_V;
      return s[ACC_W] ? '1 : s[ACC_W-1:0];
   endfunction

   function automatic logic [ACC_W-1:0] sat_dn(input logic [ACC_W-1:0] a);
      logic [ACC_W:0] s;
      s = {1'b0, a} - STEP_V;
      return s[ACC_W] ? '0 : s[ACC_W-1:0];
   endfunction

   function automatic logic [ACC_W-1:0] toward_base(input logic [ACC_W-1:0] a);
      if (a > BASE_V)      return a - ACC_W'(1);
      else if (a < BASE_V) return a + ACC_W'(1);
      else                 return a;
   endfunction

   always_comb begin
      acc_next = acc;
      if (tick) begin
         case ({stim_up, stim_dn})
            2'b10:   acc_next = sat_up(acc);
            2'b01:   acc_next = sat_dn(acc);
            2'b11:   acc_next = acc;
            default: if (decay_step && !hold) acc_next = toward_base(acc);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= BASE_V;
         level <= LVL_RST;
      end else begin
         acc   <= acc_next;
         level <= acc[ACC_W-1 -: LVL_W];
      end
   end

`ifdef NT_BANK_DEBUG_EN
   assign acc_raw = acc;
`endif

endmodule

// File: rtl/neurotransmitter_bank.sv
// Multi-channel neurotransmitter accumulator bank with a shared decay counter.
// Optional macro NT_BANK_DEBUG_EN adds the dbg_acc raw-accumulator port.
module neurotransmitter_bank
   import nt_pkg::*;
#(
   parameter int NUM_CH       = NT_NUM_CH,
   parameter int ACC_W        = NT_ACC_W,
   parameter int LVL_W        = NT_LVL_W,
   parameter int STEP         = NT_STEP,
   parameter int BASELINE     = NT_BASELINE,
   parameter int DECAY_PERIOD = NT_DECAY_PERIOD
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tick,
   input  logic [NUM_CH-1:0]       stim_up,
   input  logic [NUM_CH-1:0]       stim_dn,
   input  logic [NUM_CH-1:0]       hold,
   output logic [NUM_CH*LVL_W-1:0] level_out,
   output logic                    decay_pulse
`ifdef NT_BANK_DEBUG_EN
   ,output logic [NUM_CH*ACC_W-1:0] dbg_acc
`endif
);

   localparam int                CNT_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECAY_PERIOD - 1);

   logic [CNT_W-1:0] cnt;
   logic             decay_step;

   // With DECAY_PERIOD=1 the counter sits at 0 and every tick is a decay step.
   assign decay_step = tick && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         decay_pulse <= 1'b0;
      end else begin
         decay_pulse <= decay_step;
         if (tick) cnt <= decay_step ? '0 : cnt + CNT_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      nt_channel #(
         .ACC_W    (ACC_W),
         .LVL_W    (LVL_W),
         .STEP     (STEP),
         .BASELINE (BASELINE)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .tick       (tick),
         .stim_up    (stim_up[i]),
         .stim_dn    (stim_dn[i]),
         .hold       (hold[i]),
         .decay_step (decay_step),
         .level      (level_out[i*LVL_W +: LVL_W])
`ifdef NT_BANK_DEBUG_EN
         ,.acc_raw   (dbg_acc[i*ACC_W +: ACC_W])
`endif
      );
   end

endmodule

// File: tb/tb_neurotransmitter_bank.sv
// Directed bench for neurotransmitter_bank (default parameters) with a
// queue-based scoreboard of expected level words.
module tb_neurotransmitter_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [4:0] stim_up;
   logic [4:0] stim_dn;
   logic [4:0] hold;
   logic [9:0] level_out;
   logic       decay_pulse;
`ifdef NT_BANK_DEBUG_EN
   logic [34:0] dbg_acc;
`endif

   neurotransmitter_bank dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .stim_up     (stim_up),
      .stim_dn     (stim_dn),
      .hold        (hold),
      .level_out   (level_out),
      .decay_pulse (decay_pulse)
`ifdef NT_BANK_DEBUG_EN
      ,.dbg_acc    (dbg_acc)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int         macc[5];
   int         mcnt;
   logic [9:0] lvl_q[$];

   localparam logic [9:0] RST_LVL = 10'b10_10_10_10_10;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [9:0] model_lvl();
      logic [9:0] r;
      for (int i = 0; i < 5; i++) r[i*2 +: 2] = 2'(macc[i] / 32);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) macc[i] = 64;
      mcnt = 0;
      lvl_q.delete();
      lvl_q.push_back(model_lvl());
   endtask

   task automatic model_edge(output logic ds);
      ds = tick && (mcnt == 15);
      if (tick) begin
         mcnt = ds ? 0 : mcnt + 1;
         for (int i = 0; i < 5; i++) begin
            if (stim_up[i] && !stim_dn[i])
               macc[i] = (macc[i] + 4 > 127) ? 127 : macc[i] + 4;
            else if (stim_dn[i] && !stim_up[i])
               macc[i] = (macc[i] < 4) ? 0 : macc[i] - 4;
            else if (!stim_up[i] && !stim_dn[i] && ds && !hold[i]) begin
               if (macc[i] > 64)      macc[i] = macc[i] - 1;
               else if (macc[i] < 64) macc[i] = macc[i] + 1;
            end
         end
      end
   endtask

   task automatic step(input logic t, input logic [4:0] u, input logic [4:0] d, input logic [4:0] h);
      logic       ds;
      logic [9:0] exp_lvl;
      tick = t; stim_up = u; stim_dn = d; hold = h;
      @(posedge clk); #1;
      model_edge(ds);
      if (lvl_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         exp_lvl = 'x;
      end else begin
         exp_lvl = lvl_q.pop_front();
      end
      check("level_out", 32'(level_out), 32'(exp_lvl));
      check("decay_pulse", 32'(decay_pulse), 32'(ds));
`ifdef NT_BANK_DEBUG_EN
      for (int i = 0; i < 5; i++) check("dbg_acc", 32'(dbg_acc[i*7 +: 7]), 32'(macc[i]));
`endif
      lvl_q.push_back(model_lvl());
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 5'h00, 5'h00, 5'h00);
   endtask

   task automatic idle_until_cnt(input int c, input logic [4:0] h);
      for (int k = 0; k < 40 && mcnt != c; k++) step(1'b1, 5'h00, 5'h00, h);
   endtask

   task automatic idle_until_acc(input int ch, input int v);
      for (int k = 0; k < 400 && macc[ch] != v; k++) idle(1);
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; stim_up = '0; stim_dn = '0; hold = '0;
      #12;
      check("reset_level", 32'(level_out), 32'(RST_LVL));
      check("reset_pulse", 32'(decay_pulse), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // idle: baseline holds, decay_pulse every 16th tick
      idle(40);

      // channel 1 pushed up until saturation
      for (int k = 0; k < 20; k++) step(1'b1, 5'b00010, 5'h00, 5'h00);
      idle(2);

      // channel 0 pushed down to zero, then relaxes back to baseline
      for (int k = 0; k < 20; k++) step(1'b1, 5'h00, 5'b00001, 5'h00);
      idle(1100);

      // channel 2 at 70, both strobes across a decay tick
      step(1'b1, 5'b00100, 5'h00, 5'h00);
      step(1'b1, 5'b00100, 5'h00, 5'h00);
      idle_until_acc(2, 70);
      idle_until_cnt(14, 5'h00);
      for (int k = 0; k < 3; k++) step(1'b1, 5'b00100, 5'b00100, 5'h00);
      idle(2);

      // channel 2 at 63, where a missed suppression would flip the level
      for (int k = 0; k < 3; k++) step(1'b1, 5'h00, 5'b00100, 5'h00);
      idle_until_acc(2, 63);
      idle_until_cnt(14, 5'h00);
      for (int k = 0; k < 3; k++) step(1'b1, 5'b00100, 5'b00100, 5'h00);
      idle(2);
      idle_until_acc(2, 64);

      // channel 3 at 96 held for 64 ticks, then released
      for (int k = 0; k < 8; k++) step(1'b1, 5'b01000, 5'h00, 5'h00);
      for (int k = 0; k < 64; k++) step(1'b1, 5'h00, 5'h00, 5'b01000);
      idle(40);

      // channel 4 at 120, counter at 9, then asynchronous reset mid-cycle
      for (int k = 0; k < 14; k++) step(1'b1, 5'b10000, 5'h00, 5'b10000);
      idle_until_cnt(9, 5'b10000);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrun_reset_level", 32'(level_out), 32'(RST_LVL));
      check("midrun_reset_pulse", 32'(decay_pulse), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // strobes without tick are ignored; counter restarts from 0
      for (int k = 0; k < 5; k++) step(1'b0, 5'h00, 5'h1F, 5'h00);
      for (int k = 0; k < 5; k++) step(1'b0, 5'h1F, 5'h00, 5'h00);
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
